ppu_bg_fetch: RTL and testbench
===============================

Name: ppu_bg_fetch

Overview:
PPU-side initiator for the background tile fetch on the PPU bus (ppu_addr/ppu_rd/ppu_data). Drives the cartridge CHR responder and the CIRAM nametable path.
Runs the 8-dot fetch group: nametable byte, attribute byte, pattern low, pattern high. Delivers one assembled tile per group to the background shifters and pulses tile_done so scroll logic can advance coarse X.
Sits inside the PPU between the loopy-v scroll register and the background pixel pipeline.

Parameters:
PPU_ADDR_W, 14, PPU bus address width (fixed by the NES PPU memory map)

Ports:
clk_ppu  in  1  PPU clock, one dot per cycle
rst_n  in  1  asynchronous active-low reset
fetch_en  in  1  level; rendering enabled and in a background fetch window
v_addr  in  15  loopy v: [14:12] fine Y, [11:10] nametable, [9:5] coarse Y, [4:0] coarse X
bg_table  in  1  background pattern table select (PPUCTRL bit 4)
ppu_addr  out  14  PPU bus address
ppu_rd  out  1  read strobe
ppu_wr  out  1  write strobe; constant 0, this block never writes
ppu_data_i  in  8  read data; valid in the cycle after the address cycle (responder registers on clk_ppu)
tile_nt  out  8  nametable (tile index) byte of last completed tile
tile_attr  out  2  palette bits selected from the attribute byte
tile_pat_lo  out  8  pattern plane 0
tile_pat_hi  out  8  pattern plane 1
tile_valid  out  1  one-cycle pulse: all tile_* outputs updated this cycle
tile_done  out  1  one-cycle pulse, coincident with tile_valid; request coarse-X increment

Behaviour:
- States: IDLE, NT_A, NT_D, AT_A, AT_D, LO_A, LO_D, HI_A, HI_D. Each state lasts one clk_ppu cycle, so a group is exactly 8 cycles.
- IDLE -> NT_A when fetch_en=1. Otherwise stay.
- Fixed chain NT_A -> NT_D -> AT_A -> AT_D -> LO_A -> LO_D -> HI_A -> HI_D.
- HI_D -> NT_A if fetch_en=1 (back-to-back groups, no bubble). Otherwise HI_D -> IDLE.
- fetch_en dropping mid-group is ignored: the group completes, and the block then goes to IDLE.
- v_addr and bg_table are sampled into internal registers in NT_A and used for the whole group. Changes during a group have no effect until the next group.
- Address per pair; ppu_addr is held through both the _A and _D cycle:
  - NT: 14'h2000 | v[11:0]
  - AT: 14'h23C0 | v[11:10]<<10 | v[9:7]<<3 | v[4:2]
  - LO: bg_table<<12 | nt_byte<<4 | 0<<3 | v[14:12]
  - HI: the LO address | 8
- LO/HI addresses use the nt_byte captured in NT_D of the same group.
- ppu_rd=1 in every _A and _D state. ppu_rd=0 and ppu_addr=0 in IDLE.
- Capture: ppu_data_i is registered at the clock edge ending each _D state.
  - NT_D -> nt_byte.
  - AT_D -> attr_byte, reduced to 2 bits by shift = {v[6], v[1]}*2, i.e. attr_byte[shift+1:shift].
  - LO_D -> lo.
  - HI_D -> hi.
- Tile outputs update together at the edge ending HI_D. tile_valid/tile_done are high for exactly the following cycle (the next NT_A or IDLE). Outputs hold their value until the next tile completes.
- Partial data is never exposed on tile_* outputs.
- Reset (rst_n low, any time, including mid-group) forces immediately:
  - state IDLE
  - ppu_addr=0, ppu_rd=0, ppu_wr=0
  - tile_nt=0, tile_attr=0, tile_pat_lo=0, tile_pat_hi=0
  - tile_valid=0, tile_done=0
- After reset release, the first group starts on the first cycle with fetch_en=1.

Decomposition:
- Shared package ppu_pkg holds:
  - the fetch state enum (bg_fetch_state_t)
  - constants NT_BASE=14'h2000, AT_OFFSET=10'h3C0, PT_PLANE_HI=4'h8
- One sub-module is natural: ppu_bg_addr_gen, a combinational function of (state pair, latched v, bg_table, nt_byte) to the 14-bit address. The FSM and capture registers stay in the top.

Test Plan:
- Reset state: rst_n=0 at any time -> all outputs 0, state IDLE; ppu_rd stays 0 while fetch_en=0.
- Single group, v=15'h0000, bg_table=0, responder NT=8'h41, AT=8'hE4:
  - addresses 2000,2000,23C0,23C0,0410,0410,0418,0418 on consecutive cycles
  - tile_nt=41, tile_attr=0 (bits 1:0 of E4)
  - tile_valid pulses 8 cycles after start
- Attribute quadrant/extremes, v=15'h7FFF, bg_table=1, NT=8'hFF, AT=8'hE4:
  - NT addr 2FFF, AT addr 2FFF
  - tile_attr=2'b11 (bits 7:6 of E4)
  - LO addr 1FF7, HI addr 1FFF
- Back-to-back: fetch_en held high for 3 groups -> NT_A follows HI_D with no gap; tile_valid exactly every 8 cycles; v_addr change mid-group only affects the next group.
- fetch_en deassert at the LO_A cycle -> group completes, tile_valid pulses once, then IDLE with ppu_rd=0.
- rst_n asserted during LO_D -> outputs cleared asynchronously, no tile_valid; restart after release gives a clean full group.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared PPU types and constants.
// Background fetch states, address constants and attribute helper.
package ppu_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_NT_A,
        ST_NT_D,
        ST_AT_A,
        ST_AT_D,
        ST_LO_A,
        ST_LO_D,
        ST_HI_A,
        ST_HI_D
    } bg_fetch_state_t;

    typedef enum logic [1:0] {
        PAIR_NT,
        PAIR_AT,
        PAIR_LO,
        PAIR_HI
    } fetch_pair_t;

    localparam logic [13:0] NT_BASE     = 14'h2000;
    localparam logic [9:0]  AT_OFFSET   = 10'h3C0;
    localparam logic [3:0]  PT_PLANE_HI = 4'h8;

    // Pick the 2-bit palette field of the quadrant {coarse_y[1], coarse_x[1]}
    function automatic logic [1:0] attr_pick(
        input logic [7:0] attr_byte,
        input logic [1:0] quad
    );
        logic [7:0] sh;
        sh = attr_byte >> {quad, 1'b0};
        return sh[1:0];
    endfunction

endpackage

// File: rtl/ppu_bg_addr_gen.sv
// Background fetch address generator.
// Maps the current fetch pair and latched scroll state to a PPU address.
module ppu_bg_addr_gen
    import ppu_pkg::*;
(
    input  fetch_pair_t  pair,
    input  logic [14:0]  v,
    input  logic         bg_table,
    input  logic [7:0]   nt_byte,
    output logic [13:0]  addr
);

    logic [13:0] pt_addr;

    // Nametable, attribute or pattern-plane address for the active pair
    always_comb begin
        addr    = '0;
        pt_addr = {1'b0, bg_table, nt_byte, 1'b0, v[14:12]};
        unique case (pair)
            PAIR_NT: addr = NT_BASE | {2'b00, v[11:0]};
            PAIR_AT: addr = NT_BASE
                          | {2'b00, v[11:10], AT_OFFSET}
                          | {8'b0, v[9:7], v[4:2]};
            PAIR_LO: addr = pt_addr;
            PAIR_HI: addr = pt_addr | {10'b0, PT_PLANE_HI};
            default: addr = '0;
        endcase
    end

endmodule

// File: rtl/ppu_bg_fetch.sv
// PPU background tile fetcher.
// 8-dot NT/AT/LO/HI fetch group, delivering one assembled tile per group.
module ppu_bg_fetch
    import ppu_pkg::*;
#(
    parameter int PPU_ADDR_W = 14
) (
    input  logic                  clk_ppu,
    input  logic                  rst_n,
    input  logic                  fetch_en,
    input  logic [14:0]           v_addr,
    input  logic                  bg_table,
    output logic [PPU_ADDR_W-1:0] ppu_addr,
    output logic                  ppu_rd,
    output logic                  ppu_wr,
    input  logic [7:0]            ppu_data_i,
    output logic [7:0]            tile_nt,
    output logic [1:0]            tile_attr,
    output logic [7:0]            tile_pat_lo,
    output logic [7:0]            tile_pat_hi,
    output logic                  tile_valid,
    output logic                  tile_done
);

    bg_fetch_state_t state_q, state_d;

    logic [14:0] v_q, v_d;
    logic        bg_q, bg_d;
    logic [7:0]  nt_q, nt_d;
    logic [1:0]  attr_q, attr_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  t_nt_q, t_nt_d;
    logic [1:0]  t_attr_q, t_attr_d;
    logic [7:0]  t_lo_q, t_lo_d;
    logic [7:0]  t_hi_q, t_hi_d;
    logic        t_valid_q, t_valid_d;

    fetch_pair_t pair;
    logic [14:0] v_eff;
    logic        bg_eff;
    logic [13:0] gen_addr;

    // Next-state logic for the fixed 8-cycle fetch chain
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (fetch_en) state_d = ST_NT_A;
            ST_NT_A: state_d = ST_NT_D;
            ST_NT_D: state_d = ST_AT_A;
            ST_AT_A: state_d = ST_AT_D;
            ST_AT_D: state_d = ST_LO_A;
            ST_LO_A: state_d = ST_LO_D;
            ST_LO_D: state_d = ST_HI_A;
            ST_HI_A: state_d = ST_HI_D;
            ST_HI_D: state_d = fetch_en ? ST_NT_A : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_ppu or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Scroll latch, per-pair data capture and tile assembly
    always_comb begin
        v_d       = v_q;
        bg_d      = bg_q;
        nt_d      = nt_q;
        attr_d    = attr_q;
        lo_d      = lo_q;
        t_nt_d    = t_nt_q;
        t_attr_d  = t_attr_q;
        t_lo_d    = t_lo_q;
        t_hi_d    = t_hi_q;
        t_valid_d = 1'b0;
        unique case (state_q)
            ST_NT_A: begin
                v_d  = v_addr;
                bg_d = bg_table;
            end
            ST_NT_D: nt_d   = ppu_data_i;
            ST_AT_D: attr_d = attr_pick(ppu_data_i, {v_q[6], v_q[1]});
            ST_LO_D: lo_d   = ppu_data_i;
            ST_HI_D: begin
                t_nt_d    = nt_q;
                t_attr_d  = attr_q;
                t_lo_d    = lo_q;
                t_hi_d    = ppu_data_i;
                t_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk_ppu or negedge rst_n) begin
        if (!rst_n) begin
            v_q       <= '0;
            bg_q      <= 1'b0;
            nt_q      <= '0;
            attr_q    <= '0;
            lo_q      <= '0;
            t_nt_q    <= '0;
            t_attr_q  <= '0;
            t_lo_q    <= '0;
            t_hi_q    <= '0;
            t_valid_q <= 1'b0;
        end else begin
            v_q       <= v_d;
            bg_q      <= bg_d;
            nt_q      <= nt_d;
            attr_q    <= attr_d;
            lo_q      <= lo_d;
            t_nt_q    <= t_nt_d;
            t_attr_q  <= t_attr_d;
            t_lo_q    <= t_lo_d;
            t_hi_q    <= t_hi_d;
            t_valid_q <= t_valid_d;
        end
    end

    // Pair select; NT_A addresses straight from v_addr before it is latched
    always_comb begin
        pair   = PAIR_NT;
        v_eff  = v_q;
        bg_eff = bg_q;
        unique case (state_q)
            ST_NT_A: begin
                pair   = PAIR_NT;
                v_eff  = v_addr;
                bg_eff = bg_table;
            end
            ST_NT_D:          pair = PAIR_NT;
            ST_AT_A, ST_AT_D: pair = PAIR_AT;
            ST_LO_A, ST_LO_D: pair = PAIR_LO;
            ST_HI_A, ST_HI_D: pair = PAIR_HI;
            default:          pair = PAIR_NT;
        endcase
    end

    ppu_bg_addr_gen u_addr_gen (
        .pair     (pair),
        .v        (v_eff),
        .bg_table (bg_eff),
        .nt_byte  (nt_q),
        .addr     (gen_addr)
    );

    assign ppu_rd      = (state_q != ST_IDLE);
    assign ppu_addr    = ppu_rd ? gen_addr : '0;
    assign ppu_wr      = 1'b0;
    assign tile_nt     = t_nt_q;
    assign tile_attr   = t_attr_q;
    assign tile_pat_lo = t_lo_q;
    assign tile_pat_hi = t_hi_q;
    assign tile_valid  = t_valid_q;
    assign tile_done   = t_valid_q;

endmodule

// File: tb/tb_ppu_bg_fetch.sv
// Testbench for ppu_bg_fetch.
// Directed groups; monitor checks bus addresses and tiles against queues.
module tb_ppu_bg_fetch;

    typedef struct {
        logic [7:0] nt;
        logic [1:0] at;
        logic [7:0] lo;
        logic [7:0] hi;
        int         cyc;
    } tile_t;

    logic        clk_ppu = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic [14:0] v_addr;
    logic        bg_table;
    logic [13:0] ppu_addr;
    logic        ppu_rd;
    logic        ppu_wr;
    logic [7:0]  ppu_data_i = 8'h00;
    logic [7:0]  tile_nt;
    logic [1:0]  tile_attr;
    logic [7:0]  tile_pat_lo;
    logic [7:0]  tile_pat_hi;
    logic        tile_valid;
    logic        tile_done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [13:0] addr_q[$];
    tile_t       tile_q[$];
    tile_t       hold;

    logic [7:0] tbl[4];
    logic [2:0] ph = 3'd0;

    ppu_bg_fetch dut (
        .clk_ppu     (clk_ppu),
        .rst_n       (rst_n),
        .fetch_en    (fetch_en),
        .v_addr      (v_addr),
        .bg_table    (bg_table),
        .ppu_addr    (ppu_addr),
        .ppu_rd      (ppu_rd),
        .ppu_wr      (ppu_wr),
        .ppu_data_i  (ppu_data_i),
        .tile_nt     (tile_nt),
        .tile_attr   (tile_attr),
        .tile_pat_lo (tile_pat_lo),
        .tile_pat_hi (tile_pat_hi),
        .tile_valid  (tile_valid),
        .tile_done   (tile_done)
    );

    always #5 clk_ppu = ~clk_ppu;

    always @(posedge clk_ppu) cyc <= cyc + 1;

    // Responder: registered read data, NT/AT/LO/HI by position in the group
    always @(posedge clk_ppu) begin
        if (ppu_rd) begin
            ppu_data_i <= tbl[ph[2:1]];
            ph         <= ph + 3'd1;
        end else begin
            ppu_data_i <= 8'h00;
            ph         <= 3'd0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic miss(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: unexpected event at cyc %0d", name, cyc);
    endtask

    // Monitor: pops expected bus addresses and tiles as the DUT shows them
    always @(negedge clk_ppu) begin
        if (!rst_n) hold = '{8'h00, 2'b00, 8'h00, 8'h00, 0};
        if (ppu_rd) begin
            if (addr_q.size() == 0) miss("unexpected_rd");
            else chk("ppu_addr", 32'(ppu_addr), 32'(addr_q.pop_front()));
        end else begin
            chk("idle_addr", 32'(ppu_addr), 32'h0);
        end
        chk("ppu_wr", 32'(ppu_wr), 32'h0);
        if (tile_valid) begin
            if (tile_q.size() == 0) begin
                miss("unexpected_tile_valid");
            end else begin
                hold = tile_q.pop_front();
                chk("tile_cycle", cyc, hold.cyc);
            end
        end
        chk("tile_done_eq_valid", 32'(tile_done), 32'(tile_valid));
        chk("tile_nt", 32'(tile_nt), 32'(hold.nt));
        chk("tile_attr", 32'(tile_attr), 32'(hold.at));
        chk("tile_pat_lo", 32'(tile_pat_lo), 32'(hold.lo));
        chk("tile_pat_hi", 32'(tile_pat_hi), 32'(hold.hi));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_ppu);
        #1;
    endtask

    task automatic set_tbl(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
        tbl[0] = a;
        tbl[1] = b;
        tbl[2] = c;
        tbl[3] = d;
    endtask

    task automatic push_grp(input logic [13:0] nt, input logic [13:0] at,
                            input logic [13:0] lo, input logic [13:0] hi);
        addr_q.push_back(nt);
        addr_q.push_back(nt);
        addr_q.push_back(at);
        addr_q.push_back(at);
        addr_q.push_back(lo);
        addr_q.push_back(lo);
        addr_q.push_back(hi);
        addr_q.push_back(hi);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd"}, 32'(ppu_rd), 32'h0);
        chk({tag, "_addr"}, 32'(ppu_addr), 32'h0);
        chk({tag, "_wr"}, 32'(ppu_wr), 32'h0);
        chk({tag, "_nt"}, 32'(tile_nt), 32'h0);
        chk({tag, "_attr"}, 32'(tile_attr), 32'h0);
        chk({tag, "_lo"}, 32'(tile_pat_lo), 32'h0);
        chk({tag, "_hi"}, 32'(tile_pat_hi), 32'h0);
        chk({tag, "_valid"}, 32'(tile_valid), 32'h0);
        chk({tag, "_done"}, 32'(tile_done), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        hold     = '{8'h00, 2'b00, 8'h00, 8'h00, 0};
        set_tbl(8'h00, 8'h00, 8'h00, 8'h00);
        rst_n    = 1'b0;
        fetch_en = 1'b1;
        v_addr   = 15'h0000;
        bg_table = 1'b0;
        #12;
        chk_all_zero("reset");
        step(1);
        fetch_en = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(4);
        chk("idle_no_rd", 32'(ppu_rd), 32'h0);

        // Single group, v=0, table 0
        set_tbl(8'h41, 8'hE4, 8'h81, 8'h7E);
        v_addr   = 15'h0000;
        bg_table = 1'b0;
        push_grp(14'h2000, 14'h23C0, 14'h0410, 14'h0418);
        tile_q.push_back('{8'h41, 2'b00, 8'h81, 8'h7E, cyc + 9});
        fetch_en = 1'b1;
        step(1);
        fetch_en = 1'b0;
        step(10);

        // Extremes: v=7FFF, table 1, top attribute quadrant
        set_tbl(8'hFF, 8'hE4, 8'h3C, 8'hC3);
        v_addr   = 15'h7FFF;
        bg_table = 1'b1;
        push_grp(14'h2FFF, 14'h2FFF, 14'h1FF7, 14'h1FFF);
        tile_q.push_back('{8'hFF, 2'b11, 8'h3C, 8'hC3, cyc + 9});
        fetch_en = 1'b1;
        step(1);
        fetch_en = 1'b0;
        step(10);

        // Back-to-back groups with v_addr changing mid-group
        set_tbl(8'h12, 8'h9C, 8'hA5, 8'h5A);
        v_addr   = 15'h0000;
        bg_table = 1'b0;
        push_grp(14'h2000, 14'h23C0, 14'h0120, 14'h0128);
        push_grp(14'h2042, 14'h23C0, 14'h0121, 14'h0129);
        push_grp(14'h2C41, 14'h2FC0, 14'h0122, 14'h012A);
        tile_q.push_back('{8'h12, 2'b00, 8'hA5, 8'h5A, cyc + 9});
        tile_q.push_back('{8'h12, 2'b10, 8'hA5, 8'h5A, cyc + 17});
        tile_q.push_back('{8'h12, 2'b01, 8'hA5, 8'h5A, cyc + 25});
        fetch_en = 1'b1;
        step(3);
        v_addr = 15'h1042;
        step(8);
        v_addr = 15'h2C41;
        step(8);
        fetch_en = 1'b0;
        step(10);
        chk("b2b_idle_rd", 32'(ppu_rd), 32'h0);

        // fetch_en dropped in LO_A: group still completes once
        set_tbl(8'h5B, 8'h1B, 8'hF0, 8'h0F);
        v_addr = 15'h0021;
        push_grp(14'h2021, 14'h23C0, 14'h05B0, 14'h05B8);
        tile_q.push_back('{8'h5B, 2'b11, 8'hF0, 8'h0F, cyc + 9});
        fetch_en = 1'b1;
        step(5);
        fetch_en = 1'b0;
        step(10);
        chk("drop_idle_rd", 32'(ppu_rd), 32'h0);

        // Reset asserted during LO_D: no tile, outputs cleared at once
        set_tbl(8'h77, 8'h00, 8'h11, 8'h22);
        v_addr = 15'h0000;
        addr_q.push_back(14'h2000);
        addr_q.push_back(14'h2000);
        addr_q.push_back(14'h23C0);
        addr_q.push_back(14'h23C0);
        addr_q.push_back(14'h0770);
        addr_q.push_back(14'h0770);
        fetch_en = 1'b1;
        step(6);
        #6;
        rst_n    = 1'b0;
        fetch_en = 1'b0;
        #1;
        chk_all_zero("midreset");
        step(2);
        rst_n = 1'b1;
        step(1);

        // Clean group after reset release
        set_tbl(8'h34, 8'hE4, 8'h56, 8'h78);
        v_addr   = 15'h0002;
        bg_table = 1'b0;
        push_grp(14'h2002, 14'h23C0, 14'h0340, 14'h0348);
        tile_q.push_back('{8'h34, 2'b01, 8'h56, 8'h78, cyc + 9});
        fetch_en = 1'b1;
        step(1);
        fetch_en = 1'b0;
        step(12);

        chk("addr_q_drained", addr_q.size(), 32'h0);
        chk("tile_q_drained", tile_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
